instr_sequencer: RTL and testbench

- Program store and issuer for the trainer CPU: the instruction-producing end of the CPU's 8-bit instruction / step-strobe interface.
- In IDLE it captures trainer_dip words into a small program memory, one word per load pulse.
- It replays the stored words to the CPU as instr plus a single-cycle instr_valid strobe, either free-running at a timed rate (RUN) or one word per step pulse.
- instr_valid replaces the button-driven activate strobe; instr replaces the raw DIP word at the CPU input.

---
 rtl/instr_sequencer.sv | 130 +++++++++++++
 tb/tb_instr_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: program store that captures trainer_dip words and replays them to the CPU.
// Latency: one cycle from step_pulse or timer terminal count to instr/instr_valid.
// No backpressure; pulses are acted on at once or dropped. Build option SEQ_LOOP_EN repeats the program in RUN.
module instr_sequencer #(
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int STEP_DIV = 25000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        trainer_dip,
  input  logic              load_pulse,
  input  logic              run_pulse,
  input  logic              step_pulse,
  input  logic              halt_pulse,
  input  logic              clear_pulse,
  output logic [7:0]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(STEP_DIV - 1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   timer;
  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] ptr_inc;
  logic            last_word;
  logic            timer_term;
  logic            do_issue, do_load, do_ovf, do_clear, do_start, do_halt;

  assign ptr_inc    = {1'b0, rd_ptr} + (ADDR_W + 1)'(1);
  assign last_word  = !(ptr_inc < count);
  assign timer_term = (timer == T_LAST);
  assign busy       = (state == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Pulse decode by priority halt > clear > run > step > load; next state.
  always_comb begin
    state_nxt = state;
    do_issue  = 1'b0;
    do_load   = 1'b0;
    do_ovf    = 1'b0;
    do_clear  = 1'b0;
    do_start  = 1'b0;
    do_halt   = 1'b0;
    case (state)
      IDLE: begin
        if (halt_pulse) begin
          // halt has nothing to stop here but still masks the lower-priority pulses
        end else if (clear_pulse) begin
          do_clear = 1'b1;
        end else if (run_pulse) begin
          if (count != '0) begin
            do_start  = 1'b1;
            state_nxt = RUN;
          end
        end else if (step_pulse) begin
          do_issue = (count != '0);
        end else if (load_pulse) begin
          do_load = (count < FULL);
          do_ovf  = !(count < FULL);
        end
      end
      RUN: begin
        if (halt_pulse) begin
          do_halt   = 1'b1;
          state_nxt = IDLE;
        end else if (timer_term) begin
          do_issue = 1'b1;
          if (last_word && !LOOP) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue-rate timer: free-runs 0..STEP_DIV-1 while in RUN, parked at 0 otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       timer <= '0;
    else if (do_start || do_halt)  timer <= '0;
    else if (state == RUN)         timer <= timer_term ? '0 : timer + TW'(1);
  end

  // Program memory write; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_load) mem[count[ADDR_W-1:0]] <= trainer_dip;
  end

  // Issue register, read pointer, word count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr       <= '0;
      instr_valid <= 1'b0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
    end else begin
      instr_valid <= do_issue;
      if (do_issue) begin
        instr  <= mem[rd_ptr];
        rd_ptr <= last_word ? '0 : rd_ptr + ADDR_W'(1);
      end
      if (do_clear) begin
        count  <= '0;
        rd_ptr <= '0;
      end
      if (do_load) count    <= count + (ADDR_W + 1)'(1);
      if (do_ovf)  overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenarios then random pulses, checked every cycle against a queue-based model.
// Latency: model outputs are compared 1 time unit after each rising clock edge.
// No backpressure; stimulus is pulse-only.
module tb_instr_sequencer;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int STEP_DIV = 4;
`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        trainer_dip;
  logic              load_pulse, run_pulse, step_pulse, halt_pulse, clear_pulse;
  logic [7:0]        instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              overflow;

  instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .STEP_DIV(STEP_DIV)) dut (
    .clk(clk), .rst(rst), .trainer_dip(trainer_dip),
    .load_pulse(load_pulse), .run_pulse(run_pulse), .step_pulse(step_pulse),
    .halt_pulse(halt_pulse), .clear_pulse(clear_pulse),
    .instr(instr), .instr_valid(instr_valid), .rd_ptr(rd_ptr),
    .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: program as a queue, playback as "issue every STEP_DIV cycles since run".
  logic [7:0] prog[$];
  int         m_ptr;
  bit         m_run;
  int         m_age;
  bit         m_ovf;
  logic [7:0] m_instr;
  bit         m_vld;

  task automatic model_reset();
    prog.delete();
    m_ptr = 0; m_run = 0; m_age = 0; m_ovf = 0; m_instr = 8'h00; m_vld = 0;
  endtask

  task automatic model_issue();
    m_instr = prog[m_ptr];
    m_vld   = 1;
    m_ptr++;
    if (m_ptr >= prog.size()) begin
      m_ptr = 0;
      if (!LOOP) m_run = 0;
    end
  endtask

  task automatic model_step(input bit h, input bit c, input bit r, input bit s, input bit l,
                            input logic [7:0] d);
    m_vld = 0;
    if (m_run) begin
      if (h) m_run = 0;
      else begin
        m_age++;
        if (m_age % STEP_DIV == 0) model_issue();
      end
    end else if (h) begin
    end else if (c) begin
      prog.delete();
      m_ptr = 0;
    end else if (r) begin
      if (prog.size() > 0) begin m_run = 1; m_age = 0; end
    end else if (s) begin
      if (prog.size() > 0) model_issue();
    end else if (l) begin
      if (prog.size() < DEPTH) prog.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".instr"},    32'(instr),       32'(m_instr));
    check({ph, ".valid"},    32'(instr_valid), 32'(m_vld));
    check({ph, ".rd_ptr"},   32'(rd_ptr),      32'(m_ptr));
    check({ph, ".count"},    32'(count),       32'(prog.size()));
    check({ph, ".busy"},     32'(busy),        32'(m_run));
    check({ph, ".overflow"}, 32'(overflow),    32'(m_ovf));
  endtask

  // One clock: drive pulses for this cycle, apply edge to model, compare after the edge.
  task automatic tick(input string ph, input bit h, input bit c, input bit r, input bit s,
                      input bit l, input logic [7:0] d);
    halt_pulse = h; clear_pulse = c; run_pulse = r; step_pulse = s; load_pulse = l;
    trainer_dip = d;
    @(posedge clk);
    model_step(h, c, r, s, l, d);
    #1;
    halt_pulse = 0; clear_pulse = 0; run_pulse = 0; step_pulse = 0; load_pulse = 0;
    check_all(ph);
  endtask

  task automatic idle(input string ph);
    tick(ph, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic load(input logic [7:0] d);
    tick("load", 0, 0, 0, 0, 1, d);
  endtask

  logic [7:0] w3 [3] = '{8'h15, 8'h26, 8'h07};
  logic [7:0] w5 [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
  int         p3 [3] = '{1, 2, 0};

  initial begin
    rst = 1; trainer_dip = 0;
    load_pulse = 0; run_pulse = 0; step_pulse = 0; halt_pulse = 0; clear_pulse = 0;
    model_reset();
    #1;
    check("reset.instr", 32'(instr), 32'h0);
    check("reset.valid", 32'(instr_valid), 32'h0);
    check_all("reset");
    @(posedge clk); #1;
    rst = 0;

    // Load three words.
    for (int i = 0; i < 3; i++) load(w3[i]);
    check("load3.count", 32'(count), 32'd3);
    check("load3.ovf", 32'(overflow), 32'd0);

    // Step through them from IDLE.
    for (int i = 0; i < 3; i++) begin
      tick("step", 0, 0, 0, 1, 0, 8'h00);
      check("step.instr", 32'(instr), 32'(w3[i]));
      check("step.valid", 32'(instr_valid), 32'd1);
      check("step.ptr", 32'(rd_ptr), 32'(p3[i]));
      idle("step_gap");
      check("step.valid_drop", 32'(instr_valid), 32'd0);
    end

    // Overfill, then read back every slot including the last.
    tick("clr", 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) load(w5[i]);
    check("full.count", 32'(count), 32'd4);
    check("full.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) tick("fullstep", 0, 0, 0, 1, 0, 8'h00);
    check("full.mem3", 32'(instr), 32'hD4);
    tick("clr", 0, 1, 0, 0, 0, 8'h00);
    check("clr.count", 32'(count), 32'd0);
    check("clr.ovf_sticky", 32'(overflow), 32'd1);
    tick("run_empty", 0, 0, 1, 0, 0, 8'h00);
    check("run_empty.busy", 32'(busy), 32'd0);

    // Timed playback of three words.
    for (int i = 0; i < 3; i++) load(w3[i]);
    tick("run", 0, 0, 1, 0, 0, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      idle("run_wait");
      check("run.valid_timing", 32'(instr_valid), 32'((k % 4 == 0) && (LOOP || k <= 12)));
      if (k == 12) check("run.busy_end", 32'(busy), 32'(LOOP));
      if (k == 16 && LOOP) check("run.loop_instr", 32'(instr), 32'h15);
    end
    tick("halt", 1, 0, 0, 0, 0, 8'h00);

    // Halt part-way: one issue, pointer kept, step resumes.
    tick("clr", 0, 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) load(w3[i]);
    tick("run2", 0, 0, 1, 0, 0, 8'h00);
    for (int k = 1; k <= 5; k++) idle("run2_wait");
    tick("halt2", 1, 0, 0, 0, 0, 8'h00);
    check("halt.instr", 32'(instr), 32'h15);
    check("halt.busy", 32'(busy), 32'd0);
    check("halt.ptr", 32'(rd_ptr), 32'd1);
    tick("resume", 0, 0, 0, 1, 0, 8'h00);
    check("resume.instr", 32'(instr), 32'h26);

    // Reset during RUN, then halt masking load.
    tick("run3", 0, 0, 1, 0, 0, 8'h00);
    for (int k = 1; k <= 6; k++) idle("run3_wait");
    rst = 1;
    #1;
    model_reset();
    check("midrst.valid", 32'(instr_valid), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check_all("midrst");
    #1 rst = 0;
    tick("halt_load", 1, 0, 0, 0, 1, 8'h5A);
    check("halt_load.count", 32'(count), 32'd0);

    // Random pulses.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1;
        #1;
        model_reset();
        check_all("rnd_rst");
        #1 rst = 0;
      end
      tick("rnd",
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
